// File: rtl/alu_resp_pipe.sv
// alu_resp_pipe: 2-stage elastic responder around the 32-bit, 8-op ALU; each result returns with its request tag, in order.
// Latency: a request accepted in cycle N gives rsp_valid in cycle N+2; with rsp_ready high it sustains 1 request per cycle.
// Backpressure: rsp_ready low stalls S2 and then S1; req_ready falls once both stages are full and recovers combinationally on rsp_ready.
module alu_resp_pipe #(
  parameter int TAG_W = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [31:0]      req_a,
  input  logic [31:0]      req_b,
  input  logic [2:0]       req_op,
  input  logic [TAG_W-1:0] req_tag,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_out,
  output logic             rsp_zero,
  output logic             rsp_ovf,
  output logic [TAG_W-1:0] rsp_tag,
  output logic [CNT_W-1:0] rsp_count
);

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_SLT = 3'd5;
  localparam logic [2:0] OP_SLL = 3'd6;
  localparam logic [2:0] OP_SRL = 3'd7;

  // S1: captured request operands
  logic             r_v1;
  logic [31:0]      r_a;
  logic [31:0]      r_b;
  logic [2:0]       r_op;
  logic [TAG_W-1:0] r_tag1;

  // S2: computed response
  logic             r_v2;
  logic [31:0]      r_out;
  logic             r_zero;
  logic             r_ovf;
  logic [TAG_W-1:0] r_tag2;
  logic [CNT_W-1:0] r_count;

  logic             w_adv1;
  logic             w_adv2;
  logic [31:0]      w_add;
  logic [31:0]      w_sub;
  logic [31:0]      w_res;
  logic             w_ovf;

  // S2 can take new data when empty or being drained; S1 when empty or moving into S2.
  assign w_adv2    = !r_v2 || rsp_ready;
  assign w_adv1    = !r_v1 || w_adv2;
  assign req_ready = w_adv1 && !rst;

  assign w_add = r_a + r_b;
  assign w_sub = r_a - r_b;

  // ALU between S1 and S2; overflow only meaningful for add/sub
  always_comb begin
    w_res = 32'd0;
    w_ovf = 1'b0;
    case (r_op)
      OP_ADD: begin
        w_res = w_add;
        w_ovf = (r_a[31] == r_b[31]) && (w_add[31] != r_a[31]);
      end
      OP_SUB: begin
        w_res = w_sub;
        w_ovf = (r_a[31] != r_b[31]) && (w_sub[31] != r_a[31]);
      end
      OP_AND:  w_res = r_a & r_b;
      OP_OR:   w_res = r_a | r_b;
      OP_XOR:  w_res = r_a ^ r_b;
      OP_SLT:  w_res = {31'd0, ($signed(r_a) < $signed(r_b))};
      OP_SLL:  w_res = r_a << r_b[4:0];
      OP_SRL:  w_res = r_a >> r_b[4:0];
      default: w_res = 32'd0;
    endcase
  end

  // Pipeline registers and completed-response counter; reset flushes everything in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      r_v1    <= 1'b0;
      r_a     <= 32'd0;
      r_b     <= 32'd0;
      r_op    <= 3'd0;
      r_tag1  <= '0;
      r_v2    <= 1'b0;
      r_out   <= 32'd0;
      r_zero  <= 1'b0;
      r_ovf   <= 1'b0;
      r_tag2  <= '0;
      r_count <= '0;
    end else begin
      if (w_adv2) begin
        r_v2 <= r_v1;
        // Payload only moves with a real item so idle bubbles leave rsp_* untouched
        if (r_v1) begin
          r_out  <= w_res;
          r_zero <= (w_res == 32'd0);
          r_ovf  <= w_ovf;
          r_tag2 <= r_tag1;
        end
      end
      if (w_adv1) begin
        r_v1 <= req_valid && req_ready;
        if (req_valid && req_ready) begin
          r_a    <= req_a;
          r_b    <= req_b;
          r_op   <= req_op;
          r_tag1 <= req_tag;
        end
      end
      if (r_v2 && rsp_ready) begin
        r_count <= r_count + CNT_W'(1);
      end
    end
  end

  assign rsp_valid = r_v2;
  assign rsp_out   = r_out;
  assign rsp_zero  = r_zero;
  assign rsp_ovf   = r_ovf;
  assign rsp_tag   = r_tag2;
  assign rsp_count = r_count;

endmodule
